mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  Load/store unit of the MEM pipeline stage; sits directly upstream of the data memory.
//  Accepts LW/SW requests from EX via valid/ready and drives the memory's addr/wr_en/wr_data ports.
//  Absorbs the memory's 1-cycle registered read latency; returns load results, tagged and in order, to WB.
// PARAMETERS
//  p_WORD_LEN      16  data word width
//  p_ADDR_LEN      10  memory address lines; must match the data memory instance
//  p_REG_ADDR_LEN  3   destination register tag width
//  p_RESP_DEPTH    2   response FIFO depth = max loads outstanding (in flight + queued)
// PORTS
//  i_clk          in   1               clock, all state on posedge
//  i_rst_n        in   1               reset, asynchronous, active-low
//  i_req_valid    in   1               EX request valid
//  o_req_ready    out  1               request accepted when valid & ready at posedge
//  i_req_we       in   1               1 = SW, 0 = LW
//  i_req_addr     in   p_WORD_LEN      effective address from ALU (full width)
//  i_req_wdata    in   p_WORD_LEN      store data
//  i_req_rd       in   p_REG_ADDR_LEN  load destination register tag
//  o_mem_wr_en    out  1               memory write enable
//  o_mem_addr     out  p_ADDR_LEN      memory address
//  o_mem_wr_data  out  p_WORD_LEN      memory write data
//  i_mem_rd_data  in   p_WORD_LEN      memory read data, valid the cycle after o_mem_addr
//  o_resp_valid   out  1               load result valid (head of FIFO)
//  i_resp_ready   in   1               WB consumes on valid & ready at posedge
//  o_resp_data    out  p_WORD_LEN      load data
//  o_resp_rd      out  p_REG_ADDR_LEN  load destination tag
//  o_err_oob      out  1               sticky: accepted address had nonzero bits above p_ADDR_LEN
// BEHAVIOUR
//  - Reset (async assert, sync release): s1_valid=0, FIFO count=0, o_err_oob=0. Hence o_req_ready=0 while
//    i_rst_n=0, o_resp_valid=0, o_mem_wr_en=0. Mid-operation reset drops in-flight and queued loads:
//    no response for them appears after release. A store not yet at a posedge is not written.
//  - o_req_ready = (fifo_count + s1_valid) < p_RESP_DEPTH; no same-cycle pop credit; same rule for LW and SW.
//  - Address path is combinational: o_mem_addr = i_req_addr[p_ADDR_LEN-1:0]; o_mem_wr_data = i_req_wdata.
//  - o_mem_wr_en = i_req_valid & o_req_ready & i_req_we. The store commits at the acceptance posedge.
//    A store produces no response.
//  - Load accepted at posedge of cycle N (memory samples addr at the same edge):
//      s1_valid=1 and s1_rd=i_req_rd during N+1;
//      posedge end of N+1: i_mem_rd_data and s1_rd are pushed into the FIFO;
//      o_resp_valid=1 from N+2 earliest. Load-to-response latency = 2 cycles.
//  - s1_valid clears after the push unless a new load is accepted in the same cycle (pipelined, 1 load/cycle issue).
//  - Back-pressure: the FIFO push never fails, guaranteed by the ready rule. Push and pop in the same cycle:
//    count unchanged, order preserved.
//  - Responses leave strictly in acceptance order. o_resp_data/o_resp_rd are stable while valid & !ready.
//  - Ordering vs memory: SW then LW to the same address on consecutive cycles returns the new data.
//    LW then SW to the same address returns the old data. No forwarding logic is needed.
//  - OOB: if i_req_addr[p_WORD_LEN-1:p_ADDR_LEN] != 0 on acceptance (LW or SW), the access is performed
//    at the truncated (aliased) address and o_err_oob is set the next cycle. It is cleared only by reset.
//  - No request may be lost or duplicated. o_mem_wr_en is never high when o_req_ready=0.
// STRUCTURE
//  - mem_pkg (shared): lsu_req_t {we, addr, wdata, rd}, lsu_resp_t {data, rd}, default widths as localparams.
//  - Sub-module lsu_resp_fifo: p_RESP_DEPTH entries of lsu_resp_t; wrap-around rd/wr pointers plus count;
//    async active-low reset; outputs count, head, valid.
//  - mem_lsu top: ready logic, s1 stage register, OOB flag, port wiring.
// TESTING (bench instantiates mem_lsu + data memory, p_ADDR_LEN=10)
//  1. SW 0x1234 @5 at cycle 0, LW @5 rd=3 at cycle 1 -> o_resp_valid at cycle 3, data 0x1234, rd 3.
//  2. LW @1,@2,@3 back-to-back with resp_ready=1 -> ready low in cycle 2 only;
//     responses in order, 2-cycle latency each.
//  3. resp_ready=0, issue 2 LW then SW -> ready stays 0, wr_en never pulses;
//     resp_ready=1 -> both drain in order, then SW commits.
//  4. LW @0x0405 after SW 0xBEEF @0x005 -> o_mem_addr=0x005, data 0xBEEF, o_err_oob=1 until reset.
//  5. i_rst_n low while one LW in flight and one queued -> resp_valid drops immediately, ready=0;
//     after release no stale response, first new LW returns correct data.
//  6. Random LW/SW mix vs reference memory model with random resp_ready -> zero mismatches, order kept.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default widths for the MEM-stage load/store unit.
// Request and response bundles are sized by the default widths below.
package mem_pkg;

    localparam int unsigned WORD_LEN     = 16;
    localparam int unsigned ADDR_LEN     = 10;
    localparam int unsigned REG_ADDR_LEN = 3;
    localparam int unsigned RESP_DEPTH   = 2;

    typedef struct packed {
        logic                    we;
        logic [WORD_LEN-1:0]     addr;
        logic [WORD_LEN-1:0]     wdata;
        logic [REG_ADDR_LEN-1:0] rd;
    } lsu_req_t;

    typedef struct packed {
        logic [WORD_LEN-1:0]     data;
        logic [REG_ADDR_LEN-1:0] rd;
    } lsu_resp_t;

endpackage

// File: rtl/mem_lsu_fifo.sv
// In-order response queue for completed loads.
// Uses wrap-around read/write pointers plus an occupancy count.
module lsu_resp_fifo
    import mem_pkg::*;
#(
    parameter int p_DEPTH = RESP_DEPTH,
    localparam int CW = $clog2(p_DEPTH + 1)
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_push,
    input  lsu_resp_t i_push_data,
    input  logic      i_pop,
    output lsu_resp_t o_head,
    output logic      o_valid,
    output logic [CW-1:0] o_count
);

    localparam int PW = (p_DEPTH > 1) ? $clog2(p_DEPTH) : 1;

    lsu_resp_t       r_mem [p_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(p_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign w_pop   = i_pop & o_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            unique case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit in front of a 1-cycle registered data memory.
// Loads return tagged and in order; the ready rule guarantees FIFO space.
module mem_lsu
    import mem_pkg::*;
#(
    parameter int p_WORD_LEN     = WORD_LEN,
    parameter int p_ADDR_LEN     = ADDR_LEN,
    parameter int p_REG_ADDR_LEN = REG_ADDR_LEN,
    parameter int p_RESP_DEPTH   = RESP_DEPTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_we,
    input  logic [p_WORD_LEN-1:0]     i_req_addr,
    input  logic [p_WORD_LEN-1:0]     i_req_wdata,
    input  logic [p_REG_ADDR_LEN-1:0] i_req_rd,
    output logic                      o_mem_wr_en,
    output logic [p_ADDR_LEN-1:0]     o_mem_addr,
    output logic [p_WORD_LEN-1:0]     o_mem_wr_data,
    input  logic [p_WORD_LEN-1:0]     i_mem_rd_data,
    output logic                      o_resp_valid,
    input  logic                      i_resp_ready,
    output logic [p_WORD_LEN-1:0]     o_resp_data,
    output logic [p_REG_ADDR_LEN-1:0] o_resp_rd,
    output logic                      o_err_oob
);

    localparam int CW = $clog2(p_RESP_DEPTH + 1);

    lsu_req_t                  w_req;
    lsu_resp_t                 w_push_data;
    lsu_resp_t                 w_head;
    logic [CW-1:0]             w_count;
    logic [CW:0]               w_occ;
    logic                      w_accept;
    logic                      w_load_acc;
    logic                      w_oob;
    logic                      w_pop;
    logic                      r_s1_valid;
    logic [p_REG_ADDR_LEN-1:0] r_s1_rd;
    logic                      r_err_oob;

    assign w_req = '{we: i_req_we, addr: i_req_addr,
                     wdata: i_req_wdata, rd: i_req_rd};

    // Loads in flight count against FIFO space; no credit for a same-cycle pop.
    assign w_occ       = {1'b0, w_count} + {{CW{1'b0}}, r_s1_valid};
    assign o_req_ready = i_rst_n & (w_occ < (CW+1)'(p_RESP_DEPTH));

    assign w_accept      = i_req_valid & o_req_ready;
    assign w_load_acc    = w_accept & ~w_req.we;
    assign o_mem_wr_en   = w_accept & w_req.we;
    assign o_mem_addr    = w_req.addr[p_ADDR_LEN-1:0];
    assign o_mem_wr_data = w_req.wdata;
    assign w_oob         = |(w_req.addr >> p_ADDR_LEN);

    assign w_push_data = '{data: i_mem_rd_data, rd: r_s1_rd};
    assign w_pop       = o_resp_valid & i_resp_ready;
    assign o_resp_data = w_head.data;
    assign o_resp_rd   = w_head.rd;
    assign o_err_oob   = r_err_oob;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_rd    <= '0;
            r_err_oob  <= 1'b0;
        end else begin
            r_s1_valid <= w_load_acc;
            if (w_load_acc) r_s1_rd <= w_req.rd;
            if (w_accept && w_oob) r_err_oob <= 1'b1;
        end
    end

    lsu_resp_fifo #(
        .p_DEPTH (p_RESP_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (r_s1_valid),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (o_resp_valid),
        .o_count     (w_count)
    );

endmodule

// File: tb/tb_mem_lsu.sv
// Directed and randomized bench for mem_lsu with a registered-read memory.
// Expected values come from hand tables and a small reference model.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [2:0]  req_rd;
    logic        mem_wr_en;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wr_data;
    logic [15:0] mem_rd_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic [2:0]  resp_rd;
    logic        err_oob;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_lsu dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_we      (req_we),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .i_req_rd      (req_rd),
        .o_mem_wr_en   (mem_wr_en),
        .o_mem_addr    (mem_addr),
        .o_mem_wr_data (mem_wr_data),
        .i_mem_rd_data (mem_rd_data),
        .o_resp_valid  (resp_valid),
        .i_resp_ready  (resp_ready),
        .o_resp_data   (resp_data),
        .o_resp_rd     (resp_rd),
        .o_err_oob     (err_oob)
    );

    logic [15:0] dmem [1024];

    always @(posedge clk) begin
        if (mem_wr_en) dmem[mem_addr] <= mem_wr_data;
        mem_rd_data <= dmem[mem_addr];
    end

    typedef struct {
        logic        v;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [2:0]  rd;
        logic        rr;
        logic        e_rdy;
        logic        e_wen;
        logic [9:0]  e_maddr;
        logic        e_rv;
        logic [15:0] e_data;
        logic [2:0]  e_rrd;
        logic        e_oob;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  rd;
        int          t;
    } exp_t;

    vec_t        vq[$];
    exp_t        q[$];
    logic [15:0] refmem [1024];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic v, we, input logic [15:0] addr, wd,
                       input logic [2:0] rd, input logic rr,
                       input logic e_rdy, e_wen, input logic [9:0] e_maddr,
                       input logic e_rv, input logic [15:0] e_data,
                       input logic [2:0] e_rrd, input logic e_oob);
        vec_t x;
        x = '{v, we, addr, wd, rd, rr, e_rdy, e_wen, e_maddr,
              e_rv, e_data, e_rrd, e_oob};
        vq.push_back(x);
    endtask

    task automatic drive(input logic v, we, input logic [15:0] addr, wd,
                         input logic [2:0] rd, input logic rr);
        req_valid  = v;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wd;
        req_rd     = rd;
        resp_ready = rr;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rr);
        drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, rr);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            dmem[i]   = 16'hA000 + 16'(i);
            refmem[i] = 16'hA000 + 16'(i);
        end

        // Store-then-load forwarding through memory (table rows 0-3)
        add(1,1,16'h0005,16'h1234,0,1, 1,1,10'h005,0,16'h0,0,0);
        add(1,0,16'h0005,16'h0000,3,1, 1,0,10'h005,0,16'h0,0,0);
        add(0,0,16'h0000,16'h0000,0,1, 1,0,10'h000,0,16'h0,0,0);
        add(0,0,16'h0000,16'h0000,0,1, 1,0,10'h000,1,16'h1234,3,0);
        // Back-to-back loads
        add(1,0,16'h0001,16'h0000,1,1, 1,0,10'h001,0,16'h0,0,0);
        add(1,0,16'h0002,16'h0000,2,1, 1,0,10'h002,0,16'h0,0,0);
        add(1,0,16'h0003,16'h0000,4,1, 0,0,10'h003,1,16'hA001,1,0);
        add(1,0,16'h0003,16'h0000,4,1, 1,0,10'h003,1,16'hA002,2,0);
        add(0,0,16'h0000,16'h0000,0,1, 1,0,10'h000,0,16'h0,0,0);
        add(0,0,16'h0000,16'h0000,0,1, 1,0,10'h000,1,16'hA003,4,0);
        // Full FIFO blocks a store until WB drains
        add(1,0,16'h000A,16'h0000,5,0, 1,0,10'h00A,0,16'h0,0,0);
        add(1,0,16'h000B,16'h0000,6,0, 1,0,10'h00B,0,16'h0,0,0);
        add(1,1,16'h000C,16'h5555,0,0, 0,0,10'h00C,1,16'hA00A,5,0);
        add(1,1,16'h000C,16'h5555,0,0, 0,0,10'h00C,1,16'hA00A,5,0);
        add(1,1,16'h000C,16'h5555,0,1, 0,0,10'h00C,1,16'hA00A,5,0);
        add(1,1,16'h000C,16'h5555,0,1, 1,1,10'h00C,1,16'hA00B,6,0);
        add(0,0,16'h0000,16'h0000,0,1, 1,0,10'h000,0,16'h0,0,0);
        add(1,0,16'h000C,16'h0000,7,1, 1,0,10'h00C,0,16'h0,0,0);
        add(0,0,16'h0000,16'h0000,0,1, 1,0,10'h000,0,16'h0,0,0);
        add(0,0,16'h0000,16'h0000,0,1, 1,0,10'h000,1,16'h5555,7,0);
        // Out-of-range address aliases and sets the sticky flag
        add(1,1,16'h0005,16'hBEEF,0,1, 1,1,10'h005,0,16'h0,0,0);
        add(1,0,16'h0405,16'h0000,1,1, 1,0,10'h005,0,16'h0,0,0);
        add(0,0,16'h0000,16'h0000,0,1, 1,0,10'h000,0,16'h0,0,1);
        add(0,0,16'h0000,16'h0000,0,1, 1,0,10'h000,1,16'hBEEF,1,1);
        add(0,0,16'h0000,16'h0000,0,1, 1,0,10'h000,0,16'h0,0,1);

        rst_n = 1'b0;
        drive(1'b1, 1'b1, 16'h0005, 16'hFFFF, 3'd0, 1'b1);
        #1;
        chk("rst_ready", {31'b0, req_ready}, 0);
        chk("rst_wr_en", {31'b0, mem_wr_en}, 0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 0);
        next();
        next();
        chk("rst_oob", {31'b0, err_oob}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].v, vq[i].we, vq[i].addr, vq[i].wd,
                  vq[i].rd, vq[i].rr);
            #1;
            chk($sformatf("v%0d_ready", i), {31'b0, req_ready},
                {31'b0, vq[i].e_rdy});
            chk($sformatf("v%0d_wr_en", i), {31'b0, mem_wr_en},
                {31'b0, vq[i].e_wen});
            chk($sformatf("v%0d_maddr", i), {22'b0, mem_addr},
                {22'b0, vq[i].e_maddr});
            chk($sformatf("v%0d_wdata", i), {16'b0, mem_wr_data},
                {16'b0, vq[i].wd});
            chk($sformatf("v%0d_rvalid", i), {31'b0, resp_valid},
                {31'b0, vq[i].e_rv});
            if (vq[i].e_rv) begin
                chk($sformatf("v%0d_rdata", i), {16'b0, resp_data},
                    {16'b0, vq[i].e_data});
                chk($sformatf("v%0d_rrd", i), {29'b0, resp_rd},
                    {29'b0, vq[i].e_rrd});
            end
            chk($sformatf("v%0d_oob", i), {31'b0, err_oob},
                {31'b0, vq[i].e_oob});
            next();
        end

        // Reset with one load queued and one in flight
        drive(1'b1, 1'b0, 16'h0020, 16'h0, 3'd1, 1'b0);
        next();
        drive(1'b1, 1'b0, 16'h0021, 16'h0, 3'd2, 1'b0);
        next();
        idle(1'b0);
        #1;
        chk("r5_pre_valid", {31'b0, resp_valid}, 1);
        chk("r5_pre_data", {16'b0, resp_data}, 32'hA020);
        rst_n = 1'b0;
        #1;
        chk("r5_valid_drop", {31'b0, resp_valid}, 0);
        chk("r5_ready_low", {31'b0, req_ready}, 0);
        chk("r5_oob_clear", {31'b0, err_oob}, 0);
        next();
        next();
        rst_n = 1'b1;
        idle(1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("r5_stale%0d", i), {31'b0, resp_valid}, 0);
            next();
        end
        drive(1'b1, 1'b0, 16'h0020, 16'h0, 3'd3, 1'b1);
        #1;
        chk("r5_new_ready", {31'b0, req_ready}, 1);
        next();
        idle(1'b1);
        next();
        #1;
        chk("r5_new_valid", {31'b0, resp_valid}, 1);
        chk("r5_new_data", {16'b0, resp_data}, 32'hA020);
        chk("r5_new_rd", {29'b0, resp_rd}, 3);
        next();
        #1;
        chk("r5_after_pop", {31'b0, resp_valid}, 0);

        // Random LW/SW mix against a reference memory and response queue
        for (int k = 0; k < 400; k++) begin
            logic        v, we, rr, e_rdy, e_rv;
            logic [15:0] a;
            logic [9:0]  la;
            exp_t        e;
            v  = (k < 360) ? ($urandom_range(2) != 0) : 1'b0;
            we = ($urandom_range(2) == 0);
            rr = (k < 360) ? ($urandom_range(3) != 0) : 1'b1;
            la = 10'h040 + 10'($urandom_range(31));
            a  = {6'(($urandom_range(3) == 0) ? $urandom_range(63) : 0), la};
            drive(v, we, a, 16'($urandom), 3'($urandom_range(7)), rr);
            #1;
            e_rdy = (q.size() < 2);
            e_rv  = (q.size() > 0) && (q[0].t <= k);
            chk($sformatf("rnd%0d_ready", k), {31'b0, req_ready},
                {31'b0, e_rdy});
            chk($sformatf("rnd%0d_wr_en", k), {31'b0, mem_wr_en},
                {31'b0, v & e_rdy & we});
            chk($sformatf("rnd%0d_maddr", k), {22'b0, mem_addr},
                {22'b0, la});
            chk($sformatf("rnd%0d_rvalid", k), {31'b0, resp_valid},
                {31'b0, e_rv});
            if (e_rv) begin
                chk($sformatf("rnd%0d_rdata", k), {16'b0, resp_data},
                    {16'b0, q[0].data});
                chk($sformatf("rnd%0d_rrd", k), {29'b0, resp_rd},
                    {29'b0, q[0].rd});
                if (rr) void'(q.pop_front());
            end
            if (v && e_rdy) begin
                if (we) begin
                    refmem[la] = req_wdata;
                end else begin
                    e.data = refmem[la];
                    e.rd   = req_rd;
                    e.t    = k + 2;
                    q.push_back(e);
                end
            end
            next();
        end
        #1;
        chk("rnd_drained", {31'b0, resp_valid}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
